// File: rtl/mult_share_sched_pkg.sv
// Shared types and defaults for the shared-multiplier scheduler.
// Build option MULT_SHARE_SCHED_EARLY_EXIT_EN is consumed by mult_share_sched.
package mult_share_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 8;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Requester index width, never narrower than one bit.
    function automatic int id_w(input int nreq);
        return (nreq > 2) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/mult_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, wrapping.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter  int N  = NREQ_DEF,
    localparam int IW = id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_oh,
    output logic [IW-1:0] grant_idx
);

    int unsigned   pos;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = (i + 32'(ptr)) % 32'(N);
            idx = IW'(pos);
            if (!found && req[idx]) begin
                found         = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one iterative shift-add multiplier among NREQ requesters.
// Define MULT_SHARE_SCHED_EARLY_EXIT_EN to leave CALC as soon as the remaining multiplier bits are zero.
module mult_share_sched
    import mult_share_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    parameter  int W    = W_DEF,
    localparam int ID_W = id_w(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0][W-1:0] req_a,
    input  logic [NREQ-1:0][W-1:0] req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [2*W-1:0]         rsp_prod,
    input  logic                   rsp_ready,
    output logic                   busy
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id;
    logic [2*W-1:0]  acc;
    logic [2*W-1:0]  a_sh;
    logic [W-1:0]    b_sh;
    logic [CNT_W-1:0] cnt;

    logic [NREQ-1:0] grant_oh;
    logic [ID_W-1:0] grant_idx;
    logic            last_iter;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx)
    );

`ifdef MULT_SHARE_SCHED_EARLY_EXIT_EN
    // Once the shifted multiplier is empty no further additions can occur.
    assign last_iter = (cnt == CNT_W'(W-1)) || ((b_sh >> 1) == '0);
`else
    assign last_iter = (cnt == CNT_W'(W-1));
`endif

    assign req_ready = (state == IDLE) ? grant_oh : '0;
    assign rsp_valid = (state == DONE);
    assign rsp_prod  = (state == DONE) ? acc : '0;
    assign rsp_id    = (state == DONE) ? id  : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            id     <= '0;
            acc    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        a_sh  <= {{W{1'b0}}, req_a[grant_idx]};
                        b_sh  <= req_b[grant_idx];
                        acc   <= '0;
                        cnt   <= '0;
                        id    <= grant_idx;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (b_sh[0]) acc <= acc + a_sh;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_iter) state <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rr_ptr <= (id == ID_W'(NREQ-1)) ? '0 : id + ID_W'(1);
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_sched.sv
// Scoreboard bench for mult_share_sched (NREQ=4, W=8); honours MULT_SHARE_SCHED_EARLY_EXIT_EN for latency.
module tb_mult_share_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int ID_W = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0][W-1:0] req_a;
    logic [NREQ-1:0][W-1:0] req_b;
    logic [NREQ-1:0]        req_ready;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [2*W-1:0]         rsp_prod;
    logic                   rsp_ready;
    logic                   busy;

    always #5 clk = ~clk;

    mult_share_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    typedef struct {
        int id;
        int prod;
        int due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    int   m_ptr  = 0;
    logic rdy_leak;

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    function automatic int exp_lat(input int b);
        int n;
        n = 1;
        for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
`ifdef MULT_SHARE_SCHED_EARLY_EXIT_EN
        return n + 1;
`else
        return (n > 0) ? W + 1 : W + 1;
`endif
    endfunction

    function automatic int exp_grant(input logic [NREQ-1:0] m, input int p);
        for (int i = 0; i < NREQ; i++) if (m[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    // Pushes the model's expectation for the handshake happening in this cycle.
    task automatic push_exp(input int g);
        exp_t e;
        e.id   = g;
        e.prod = int'(req_a[g]) * int'(req_b[g]);
        e.due  = cycle + exp_lat(int'(req_b[g]));
        sb.push_back(e);
    endtask

    // Advances until rsp_valid is seen or the cycle budget runs out; flags any req_ready while busy.
    task automatic wait_rsp(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (req_ready !== '0) rdy_leak = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (3) tick();
        checks += 5;
        if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        if (rsp_id !== '0) begin errors++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
        if (rsp_prod !== '0) begin errors++; $display("FAIL reset_rsp_prod got %0d want 0", rsp_prod); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        m_ptr = 0;
        tick();
    endtask

    task automatic test_round_robin();
        logic ok;
        exp_t e;
        int   g;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i] = W'(i * 17 + 3);
            req_b[i] = W'(200 - i * 31);
        end
        req_valid = '1;
        rdy_leak  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            g = exp_grant(req_valid, m_ptr);
            checks++;
            if (g !== k % NREQ || req_ready !== onehot(g)) begin
                errors++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready, onehot(k % NREQ));
            end
            push_exp(g);
            tick();
            wait_rsp(ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL rr_timeout%0d got rsp_valid 0 want 1", k);
            end else begin
                e = sb.pop_front();
                checks += 3;
                if (cycle !== e.due) begin errors++; $display("FAIL rr_latency%0d got %0d want %0d", k, cycle, e.due); end
                if (rsp_id !== ID_W'(e.id)) begin errors++; $display("FAIL rr_id%0d got %0d want %0d", k, rsp_id, e.id); end
                if (rsp_prod !== 16'(e.prod)) begin errors++; $display("FAIL rr_prod%0d got %0d want %0d", k, rsp_prod, e.prod); end
                m_ptr = (e.id + 1) % NREQ;
            end
            tick();
        end
        req_valid = '0;
        checks++;
        if (rdy_leak !== 1'b0) begin errors++; $display("FAIL rr_ready_while_busy got 1 want 0"); end
    endtask

    task automatic test_single();
        logic ok;
        exp_t e;
        req_a[0] = 8'd13; req_b[0] = 8'd11;
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b want 0001", req_ready); end
        push_exp(0);
        tick();
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== '0) begin errors++; $display("FAIL single_ready_calc got %b want 0000", req_ready); end
        tick();
        tick();
        req_valid = '0;
        wait_rsp(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL single_timeout got rsp_valid 0 want 1");
        end else begin
            e = sb.pop_front();
            checks += 3;
            if (cycle !== e.due) begin errors++; $display("FAIL single_latency got %0d want %0d", cycle, e.due); end
            if (rsp_id !== ID_W'(0)) begin errors++; $display("FAIL single_id got %0d want 0", rsp_id); end
            if (rsp_prod !== 16'd143) begin errors++; $display("FAIL single_prod got %0d want 143", rsp_prod); end
            m_ptr = 1;
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || req_ready !== '0) begin
            errors++; $display("FAIL single_no_grant got busy %b ready %b want 0 0000", busy, req_ready);
        end
    endtask

    task automatic test_corners();
        logic ok;
        exp_t e;
        int   ta[5] = '{255, 0, 200, 13, 77};
        int   tb[5] = '{255, 200, 0, 1, 128};
        int   r;
        for (int k = 0; k < 5; k++) begin
            r = k % NREQ;
            req_a[r] = W'(ta[k]); req_b[r] = W'(tb[k]);
            req_valid = onehot(r);
            #1;
            checks++;
            if (req_ready !== onehot(r)) begin errors++; $display("FAIL corner_ready%0d got %b want %b", k, req_ready, onehot(r)); end
            push_exp(r);
            tick();
            req_valid = '0;
            wait_rsp(ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL corner_timeout%0d got rsp_valid 0 want 1", k);
            end else begin
                e = sb.pop_front();
                checks += 3;
                if (cycle !== e.due) begin errors++; $display("FAIL corner_latency%0d got %0d want %0d", k, cycle, e.due); end
                if (rsp_id !== ID_W'(e.id)) begin errors++; $display("FAIL corner_id%0d got %0d want %0d", k, rsp_id, e.id); end
                if (rsp_prod !== 16'(e.prod)) begin errors++; $display("FAIL corner_prod%0d got %0d want %0d", k, rsp_prod, e.prod); end
                m_ptr = (e.id + 1) % NREQ;
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic           ok;
        logic           stable;
        exp_t           e;
        logic [ID_W-1:0] id0;
        logic [2*W-1:0] p0;
        rsp_ready = 1'b0;
        req_a[2] = 8'd7; req_b[2] = 8'd9;
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_ready got %b want 0100", req_ready); end
        push_exp(2);
        tick();
        req_valid = 4'b0011;
        rdy_leak  = 1'b0;
        wait_rsp(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL bp_timeout got rsp_valid 0 want 1");
        end else begin
            e = sb.pop_front();
            checks += 3;
            if (cycle !== e.due) begin errors++; $display("FAIL bp_latency got %0d want %0d", cycle, e.due); end
            if (rsp_id !== ID_W'(e.id)) begin errors++; $display("FAIL bp_id got %0d want %0d", rsp_id, e.id); end
            if (rsp_prod !== 16'(e.prod)) begin errors++; $display("FAIL bp_prod got %0d want %0d", rsp_prod, e.prod); end
        end
        id0 = rsp_id; p0 = rsp_prod; stable = 1'b1;
        repeat (20) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_id !== id0 || rsp_prod !== p0) stable = 1'b0;
            if (req_ready !== '0) rdy_leak = 1'b1;
        end
        checks += 2;
        if (stable !== 1'b1) begin errors++; $display("FAIL bp_stable got 0 want 1"); end
        if (rdy_leak !== 1'b0) begin errors++; $display("FAIL bp_ready_leak got 1 want 0"); end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== '0) begin errors++; $display("FAIL bp_accept_cycle_ready got %b want 0000", req_ready); end
        m_ptr = 3;
        tick();
        checks += 2;
        if (rsp_valid !== 1'b0 || rsp_prod !== '0) begin
            errors++; $display("FAIL bp_release got valid %b prod %0d want 0 0", rsp_valid, rsp_prod);
        end
        if (req_ready !== onehot(exp_grant(4'b0011, m_ptr))) begin
            errors++; $display("FAIL bp_next_grant got %b want %b", req_ready, onehot(exp_grant(4'b0011, m_ptr)));
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_reset_abort();
        logic ok;
        exp_t e;
        req_a[3] = 8'd200; req_b[3] = 8'd250;
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL abort_ready got %b want 1000", req_ready); end
        tick();
        req_valid = '0;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        checks += 5;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_rsp_valid got %b want 0", rsp_valid); end
        if (rsp_prod !== '0) begin errors++; $display("FAIL abort_rsp_prod got %0d want 0", rsp_prod); end
        if (rsp_id !== '0) begin errors++; $display("FAIL abort_rsp_id got %0d want 0", rsp_id); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        if (req_ready !== '0) begin errors++; $display("FAIL abort_req_ready got %b want 0", req_ready); end
        tick();
        tick();
        rst = 1'b0;
        m_ptr = 0;
        req_a[1] = 8'd21; req_b[1] = 8'd5;
        req_a[3] = 8'd9;  req_b[3] = 8'd9;
        req_valid = 4'b1010;
        #1;
        checks++;
        if (req_ready !== onehot(exp_grant(req_valid, m_ptr))) begin
            errors++; $display("FAIL abort_regrant got %b want %b", req_ready, onehot(exp_grant(req_valid, m_ptr)));
        end
        push_exp(exp_grant(req_valid, m_ptr));
        tick();
        req_valid = '0;
        wait_rsp(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL abort_timeout got rsp_valid 0 want 1");
        end else begin
            e = sb.pop_front();
            checks += 3;
            if (cycle !== e.due) begin errors++; $display("FAIL abort_latency got %0d want %0d", cycle, e.due); end
            if (rsp_id !== ID_W'(e.id)) begin errors++; $display("FAIL abort_id got %0d want %0d", rsp_id, e.id); end
            if (rsp_prod !== 16'(e.prod)) begin errors++; $display("FAIL abort_prod got %0d want %0d", rsp_prod, e.prod); end
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_corners();
        test_backpressure();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
